// File: rtl/ibus_decode_pipe_pkg.sv
// Shared MIPS decode definitions: field encodings, ibus bit positions, bus width.
package ibus_decode_pipe_pkg;

  // Major opcodes (bits 31:26)
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL function codes (bits 5:0)
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  // REGIMM rt codes and COP0 rs codes
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;
  localparam logic [4:0] RS_MF   = 5'h00;
  localparam logic [4:0] RS_MT   = 5'h04;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  // ibus bit positions; member groups are contiguous so class bits are range ORs
  typedef enum int {
    B_ADD, B_ADDU, B_SUB, B_SUBU, B_AND, B_OR, B_XOR, B_NOR, B_SLT, B_SLTU,
    B_SLL, B_SRL, B_SRA,
    B_SLLV, B_SRLV, B_SRAV,
    B_JR, B_JALR,
    B_MULT, B_MULTU, B_DIV, B_DIVU, B_MFHI, B_MTHI, B_MFLO, B_MTLO,
    B_ADDI, B_ADDIU, B_SLTI, B_SLTIU, B_ANDI, B_ORI, B_XORI, B_LUI,
    B_LB, B_LH, B_LW, B_LBU, B_LHU,
    B_SB, B_SH, B_SW,
    B_BEQ, B_BNE, B_BLEZ, B_BGTZ, B_BLTZ, B_BGEZ,
    B_J, B_JAL,
    B_ERET, B_MFC0, B_MTC0,
    B_NOP,
    C_IR, C_SFT, C_VSFT, C_II, C_LOAD, C_SAVE, C_BRANCH,
    IBUS_N
  } ibus_bit_e;

  localparam int IBUS_W = IBUS_N;

endpackage

// File: rtl/ibus_decode_pipe_lane_decode.sv
// One-lane combinational MIPS decoder: instruction word -> one-hot ibus + reserved flag.
module ibus_lane_decode
  import ibus_decode_pipe_pkg::*;
(
  input  logic [31:0]       word_i,
  input  logic              en_i,
  output logic [IBUS_W-1:0] ibus_o,
  output logic              ri_o
);

  logic [5:0]        op;
  logic [5:0]        func;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [IBUS_W-1:0] v;

  assign op   = word_i[31:26];
  assign rs   = word_i[25:21];
  assign rt   = word_i[20:16];
  assign func = word_i[5:0];

  // Decode member bits, derive class bits, then blank the lane when disabled
  always_comb begin
    v = '0;
    case (op)
      OP_SPECIAL: begin
        case (func)
          F_SLL:   v[B_SLL]   = (word_i != '0);  // all-zero word is nop, not sll
          F_SRL:   v[B_SRL]   = 1'b1;
          F_SRA:   v[B_SRA]   = 1'b1;
          F_SLLV:  v[B_SLLV]  = 1'b1;
          F_SRLV:  v[B_SRLV]  = 1'b1;
          F_SRAV:  v[B_SRAV]  = 1'b1;
          F_JR:    v[B_JR]    = 1'b1;
          F_JALR:  v[B_JALR]  = 1'b1;
          F_MFHI:  v[B_MFHI]  = 1'b1;
          F_MTHI:  v[B_MTHI]  = 1'b1;
          F_MFLO:  v[B_MFLO]  = 1'b1;
          F_MTLO:  v[B_MTLO]  = 1'b1;
          F_MULT:  v[B_MULT]  = 1'b1;
          F_MULTU: v[B_MULTU] = 1'b1;
          F_DIV:   v[B_DIV]   = 1'b1;
          F_DIVU:  v[B_DIVU]  = 1'b1;
          F_ADD:   v[B_ADD]   = 1'b1;
          F_ADDU:  v[B_ADDU]  = 1'b1;
          F_SUB:   v[B_SUB]   = 1'b1;
          F_SUBU:  v[B_SUBU]  = 1'b1;
          F_AND:   v[B_AND]   = 1'b1;
          F_OR:    v[B_OR]    = 1'b1;
          F_XOR:   v[B_XOR]   = 1'b1;
          F_NOR:   v[B_NOR]   = 1'b1;
          F_SLT:   v[B_SLT]   = 1'b1;
          F_SLTU:  v[B_SLTU]  = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      v[B_BLTZ] = 1'b1;
        else if (rt == RT_BGEZ) v[B_BGEZ] = 1'b1;
      end
      OP_COP0: begin
        if (word_i == ERET_WORD) v[B_ERET] = 1'b1;
        else if (rs == RS_MF)    v[B_MFC0] = 1'b1;
        else if (rs == RS_MT)    v[B_MTC0] = 1'b1;
      end
      OP_J:     v[B_J]     = 1'b1;
      OP_JAL:   v[B_JAL]   = 1'b1;
      OP_BEQ:   v[B_BEQ]   = 1'b1;
      OP_BNE:   v[B_BNE]   = 1'b1;
      OP_BLEZ:  v[B_BLEZ]  = 1'b1;
      OP_BGTZ:  v[B_BGTZ]  = 1'b1;
      OP_ADDI:  v[B_ADDI]  = 1'b1;
      OP_ADDIU: v[B_ADDIU] = 1'b1;
      OP_SLTI:  v[B_SLTI]  = 1'b1;
      OP_SLTIU: v[B_SLTIU] = 1'b1;
      OP_ANDI:  v[B_ANDI]  = 1'b1;
      OP_ORI:   v[B_ORI]   = 1'b1;
      OP_XORI:  v[B_XORI]  = 1'b1;
      OP_LUI:   v[B_LUI]   = 1'b1;
      OP_LB:    v[B_LB]    = 1'b1;
      OP_LH:    v[B_LH]    = 1'b1;
      OP_LW:    v[B_LW]    = 1'b1;
      OP_LBU:   v[B_LBU]   = 1'b1;
      OP_LHU:   v[B_LHU]   = 1'b1;
      OP_SB:    v[B_SB]    = 1'b1;
      OP_SH:    v[B_SH]    = 1'b1;
      OP_SW:    v[B_SW]    = 1'b1;
      default: ;
    endcase
    v[B_NOP]    = (word_i == '0);
    v[C_IR]     = |v[B_SLTU:B_ADD];
    v[C_SFT]    = |v[B_SRA:B_SLL];
    v[C_VSFT]   = |v[B_SRAV:B_SLLV];
    v[C_II]     = |v[B_LUI:B_ADDI];
    v[C_LOAD]   = |v[B_LHU:B_LB];
    v[C_SAVE]   = |v[B_SW:B_SB];
    v[C_BRANCH] = |v[B_BGEZ:B_BEQ];
    if (!en_i) v = '0;
  end

  assign ibus_o = v;
  // Reserved: an enabled, nonzero word that matched no instruction bit
  assign ri_o   = en_i && (word_i != '0) && !(|v[B_MTC0:B_ADD]);

endmodule

// File: rtl/ibus_decode_pipe.sv
// Multi-lane decode stage feeding a DEPTH-entry FIFO of decoded beats,
// with a saturating count of accepted reserved-instruction lanes.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; valid must not depend on ready, and in_ready depends only on stored
// occupancy (never on out_ready), so a full FIFO stalls even if popping.
module ibus_decode_pipe
  import ibus_decode_pipe_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*32-1:0]     in_instr,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*IBUS_W-1:0] out_ibus,
  output logic [LANES*32-1:0]     out_instr,
  output logic [LANES-1:0]        out_mask,
  output logic [LANES-1:0]        out_ri,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [CNT_W-1:0]        ri_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W+2:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

  logic [LANES*IBUS_W-1:0] dec_ibus;
  logic [LANES-1:0]        dec_ri;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ibus_lane_decode u_dec (
      .word_i (in_instr[32*k +: 32]),
      .en_i   (in_mask[k]),
      .ibus_o (dec_ibus[IBUS_W*k +: IBUS_W]),
      .ri_o   (dec_ri[k])
    );
  end

  logic [LANES*IBUS_W-1:0] ibus_mem  [DEPTH];
  logic [LANES*32-1:0]     instr_mem [DEPTH];
  logic [LANES-1:0]        mask_mem  [DEPTH];
  logic [LANES-1:0]        ri_mem    [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W+2:0] ri_sum;
  logic             push, pop;

  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Pointer, occupancy and saturating counter next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    ri_sum   = {3'b000, cnt_q};
    for (int k = 0; k < LANES; k++) ri_sum = ri_sum + (CNT_W+3)'(dec_ri[k]);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      occ_d = occ_q + (AW+1)'(1);
      else if (!push && pop) occ_d = occ_q - (AW+1)'(1);
      if (push) cnt_d = (ri_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : ri_sum[CNT_W-1:0];
    end
  end

  // Control state; reset discards all stored beats immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage holds the already-decoded beat; contents are masked when empty
  always_ff @(posedge clk) begin
    if (push) begin
      ibus_mem[wr_ptr_q]  <= dec_ibus;
      instr_mem[wr_ptr_q] <= in_instr;
      mask_mem[wr_ptr_q]  <= in_mask;
      ri_mem[wr_ptr_q]    <= dec_ri;
    end
  end

  assign out_ibus  = out_valid ? ibus_mem[rd_ptr_q]  : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign out_mask  = out_valid ? mask_mem[rd_ptr_q]  : '0;
  assign out_ri    = out_valid ? ri_mem[rd_ptr_q]    : '0;
  assign occupancy = occ_q;
  assign ri_count  = cnt_q;

endmodule

// File: tb/tb_ibus_decode_pipe.sv
// Self-checking bench for ibus_decode_pipe (LANES=2, DEPTH=4, CNT_W=4).
module tb_ibus_decode_pipe;
  import ibus_decode_pipe_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int EW    = 64 + 2 + 2 + 2*IBUS_W;
  localparam int NT    = 15;

  logic                    clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [LANES*32-1:0]     in_instr, out_instr;
  logic [LANES-1:0]        in_mask, out_mask, out_ri;
  logic [LANES*IBUS_W-1:0] out_ibus;
  logic [2:0]              occupancy;
  logic [CNT_W-1:0]        ri_count;

  ibus_decode_pipe #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_ibus(out_ibus),
    .out_instr(out_instr), .out_mask(out_mask), .out_ri(out_ri),
    .occupancy(occupancy), .ri_count(ri_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int exp_cnt;
  int cur_a, cur_b;

  // Reference table: word, expected instruction bit (-1 = reserved), class bit (-1 = none)
  logic [31:0] tw[NT];
  int          tbit[NT];
  int          tcls[NT];

  function automatic logic [IBUS_W-1:0] exp_ibus(int idx, logic en);
    logic [IBUS_W-1:0] v;
    v = '0;
    if (en && tbit[idx] >= 0) begin
      v[tbit[idx]] = 1'b1;
      if (tcls[idx] >= 0) v[tcls[idx]] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic exp_ri(int idx, logic en);
    return en && (tbit[idx] < 0);
  endfunction

  function automatic logic [EW-1:0] make_exp(int a, int b, logic [1:0] m);
    return {tw[b], tw[a], m, exp_ri(b, m[1]), exp_ri(a, m[0]), exp_ibus(b, m[1]), exp_ibus(a, m[0])};
  endfunction

  // Driver tasks
  task automatic drive(int a, int b, logic [1:0] m, logic v);
    cur_a = a;
    cur_b = b;
    in_instr = {tw[b], tw[a]};
    in_mask = m;
    in_valid = v;
  endtask

  // One clock: scoreboard pop/push bookkeeping for this cycle's handshakes, then advance
  task automatic tick();
    logic [EW-1:0] got, exp;
    int add;
    if (!flush && out_valid && out_ready) begin
      checks++;
      got = {out_instr, out_mask, out_ri, out_ibus};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h required empty", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pop_data: got %h required %h", got, exp);
        end
      end
    end
    if (!flush && in_valid && in_ready) begin
      exp_q.push_back(make_exp(cur_a, cur_b, in_mask));
      add = int'(exp_ri(cur_a, in_mask[0])) + int'(exp_ri(cur_b, in_mask[1]));
      exp_cnt = (exp_cnt + add > 15) ? 15 : exp_cnt + add;
    end
    if (flush) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2 && out_valid; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_empty: out_valid %b queued %0d required 0 0", out_valid, exp_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic check_idle(string name);
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 ||
        {out_instr, out_mask, out_ri, out_ibus} !== '0) begin
      errors++;
      $display("FAIL %s: occ %0d valid %b data %h required all zero", name, occupancy, out_valid,
               {out_instr, out_mask, out_ri, out_ibus});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 2'b00, 1'b0);
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_outputs");
    checks++;
    if (ri_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_ri_count: got %0d required 0", ri_count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_decode();
    logic [IBUS_W-1:0] e0, e1;
    e0 = '0; e0[B_ADD] = 1'b1; e0[C_IR] = 1'b1;
    e1 = '0; e1[B_LW] = 1'b1;  e1[C_LOAD] = 1'b1;
    drive(0, 1, 2'b11, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ibus !== {e1, e0} || out_ri !== 2'b00) begin
      errors++;
      $display("FAIL decode_add_lw: valid %b ibus %h ri %b required 1 %h 00", out_valid, out_ibus,
               out_ri, {e1, e0});
    end
    drain();
  endtask

  task automatic test_ri();
    drive(13, 0, 2'b01, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_ri !== 2'b01 || ri_count !== 4'd1 || out_ibus !== '0) begin
      errors++;
      $display("FAIL ri_enabled: ri %b count %0d ibus %h required 01 1 0", out_ri, ri_count, out_ibus);
    end
    drain();
    drive(13, 13, 2'b00, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_ri !== 2'b00 || ri_count !== 4'd1 || out_ibus !== '0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ri_masked: ri %b count %0d valid %b required 00 1 1", out_ri, ri_count, out_valid);
    end
    drain();
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive($urandom_range(0, NT-1), $urandom_range(0, NT-1), 2'($urandom_range(0, 3)), 1'b1);
      checks++;
      if (in_ready !== (i < 4)) begin
        errors++;
        $display("FAIL full_in_ready_%0d: got %b required %b", i, in_ready, (i < 4));
      end
      tick();
    end
    checks++;
    if (occupancy !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: occ %0d ready %b valid %b required 4 0 1", occupancy, in_ready, out_valid);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(2, 3, 2'b11, 1'b1); tick();
    drive(4, 5, 2'b10, 1'b1); tick();
    drive(6, 7, 2'b11, 1'b1);
    out_ready = 1'b1;
    tick();
    checks++;
    if (occupancy !== 3'd2) begin
      errors++;
      $display("FAIL push_pop_occ: got %0d required 2", occupancy);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(13, 14, 2'b11, 1'b1);
      tick();
    end
    checks++;
    if (occupancy !== 3'd3) begin
      errors++;
      $display("FAIL flush_prefill: occ %0d required 3", occupancy);
    end
    drive(13, 13, 2'b11, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_idle("flush_empty");
    checks++;
    if (ri_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL flush_ri_count: got %0d required %0d", ri_count, exp_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, NT-1), $urandom_range(0, NT-1), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
    checks++;
    if (ri_count !== 4'(exp_cnt)) begin
      errors++;
      $display("FAIL random_ri_count: got %0d required %0d", ri_count, exp_cnt);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      drive(13, 14, 2'b11, 1'b1);
      tick();
      if (i == 7) begin
        checks++;
        if (ri_count !== 4'd14) begin
          errors++;
          $display("FAIL sat_at_7: got %0d required 14", ri_count);
        end
      end
    end
    checks++;
    if (ri_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_at_9: got %0d required 15", ri_count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(0, 1, 2'b11, 1'b1); tick();
    drive(13, 2, 2'b11, 1'b1); tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_idle("reset_mid_outputs");
    checks++;
    if (ri_count !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_count: count %0d ready %b required 0 1", ri_count, in_ready);
    end
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tw[0]  = 32'h0085_1020; tbit[0]  = B_ADD;  tcls[0]  = C_IR;
    tw[1]  = 32'h8C43_0004; tbit[1]  = B_LW;   tcls[1]  = C_LOAD;
    tw[2]  = 32'hAC43_0004; tbit[2]  = B_SW;   tcls[2]  = C_SAVE;
    tw[3]  = 32'h1043_0004; tbit[3]  = B_BEQ;  tcls[3]  = C_BRANCH;
    tw[4]  = 32'h0002_1080; tbit[4]  = B_SLL;  tcls[4]  = C_SFT;
    tw[5]  = 32'h0043_1007; tbit[5]  = B_SRAV; tcls[5]  = C_VSFT;
    tw[6]  = 32'h2043_0004; tbit[6]  = B_ADDI; tcls[6]  = C_II;
    tw[7]  = 32'h0800_0010; tbit[7]  = B_J;    tcls[7]  = -1;
    tw[8]  = 32'h0441_0004; tbit[8]  = B_BGEZ; tcls[8]  = C_BRANCH;
    tw[9]  = 32'h4082_6000; tbit[9]  = B_MTC0; tcls[9]  = -1;
    tw[10] = 32'h4200_0018; tbit[10] = B_ERET; tcls[10] = -1;
    tw[11] = 32'h0000_0000; tbit[11] = B_NOP;  tcls[11] = -1;
    tw[12] = 32'h0043_0018; tbit[12] = B_MULT; tcls[12] = -1;
    tw[13] = 32'hFC00_0000; tbit[13] = -1;     tcls[13] = -1;
    tw[14] = 32'h7C00_0000; tbit[14] = -1;     tcls[14] = -1;

    test_reset();
    test_decode();
    test_ri();
    test_full();
    test_back_to_back();
    test_flush();
    test_random();
    test_saturate();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
